counter_monitor: RTL

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/counter_monitor.sv
// Watches an external up-counter, predicts its next value and locks onto it after LOCK_LEN
// consecutive matches; reports mismatches seen while locked and tallies verified wraps.
module counter_monitor #(
    parameter int unsigned CNTR_WIDTH = 3,
    parameter int unsigned ERR_WIDTH  = 8,
    parameter int unsigned LOCK_LEN   = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  cnt_clr,
    input  logic                  cnt_en,
    input  logic [CNTR_WIDTH-1:0] cnt_in,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic [ERR_WIDTH-1:0]  wrap_cnt,
    output logic [CNTR_WIDTH-1:0] exp_cnt
);

    typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

    localparam logic [3:0]            LockLen = 4'(LOCK_LEN);
    localparam logic [CNTR_WIDTH-1:0] CntOne  = CNTR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0]  ErrOne  = ERR_WIDTH'(1);

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [3:0]             match_q, match_d;
    logic                   wrap_arm_q, wrap_arm_d;
    logic [CNTR_WIDTH-1:0]  exp_d;
    logic                   err_d;
    logic                   locked_d;
    logic [ERR_WIDTH-1:0]   err_cnt_d, wrap_cnt_d;
    logic                   sample_ok;

    assign sample_ok = (cnt_in == exp_cnt);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        match_d    = match_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt;
        wrap_cnt_d = wrap_cnt;
        // cnt_clr wins over cnt_en and never arms a wrap
        exp_d      = cnt_clr ? '0 : (cnt_en ? cnt_in + CntOne : cnt_in);
        wrap_arm_d = (&cnt_in) & cnt_en & ~cnt_clr;

        unique case (state_q)
            StUnlocked: begin
                state_d = StLocking;
                match_d = '0;
                valid_d = 1'b1;
            end
            StLocking: begin
                if (valid_q) begin
                    if (sample_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 >= LockLen) begin
                            state_d = StLocked;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            StLocked: begin
                if (!sample_ok) begin
                    err_d   = 1'b1;
                    state_d = StUnlocked;
                    valid_d = 1'b0;
                    if (err_cnt != '1) begin
                        err_cnt_d = err_cnt + ErrOne;
                    end
                end else if (wrap_arm_q && (cnt_in == '0)) begin
                    wrap_cnt_d = wrap_cnt + ErrOne;
                end
            end
            default: state_d = StUnlocked;
        endcase

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= StUnlocked;
            valid_q    <= 1'b0;
            match_q    <= '0;
            wrap_arm_q <= 1'b0;
            exp_cnt    <= '0;
            err        <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            wrap_arm_q <= wrap_arm_d;
            exp_cnt    <= exp_d;
            err        <= err_d;
            locked     <= locked_d;
            err_cnt    <= err_cnt_d;
            wrap_cnt   <= wrap_cnt_d;
        end
    end

endmodule
